// File: rtl/axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_pkg                                                  |
// | Brief    : Shared AXI4 encodings and write-initiator state type     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2
  } wr_init_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_burst_check                                          |
// | Brief    : Combinational AXI burst legality check (size, 4KB page)  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_burst_check
  import axi_pkg::*;
(
  input  logic [11:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  output logic        illegal
);

  logic [16:0] w_bytes;
  logic [17:0] w_end;

  // Widths cover the worst case (256 beats x 128 bytes) plus a page offset.
  always_comb begin
    w_bytes = (17'(len) + 17'd1) << size;
    w_end   = 18'(addr) + 18'(w_bytes);
    illegal = (size > 3'd3) || (w_end > 18'(PAGE_BYTES));
  end

endmodule
`default_nettype wire

// File: rtl/axi_write_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : axi_write_initiator                                      |
// | Brief    : AXI4 write master: local cmd/data in, AW/W out, B back   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_write_initiator
  import axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_id,
  output logic        cmd_err,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data,
  input  logic [7:0]  din_strb,
  output logic [1:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [63:0] WDATA,
  output logic [7:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic        resp_valid,
  output logic [1:0]  resp_id,
  output logic        resp_err,
  output logic        unexpected_b
);

  localparam int CNT_W = 4;

  wr_init_state_t   r_state;
  logic [31:0]      r_addr;
  logic [7:0]       r_len;
  logic [2:0]       r_size;
  logic [1:0]       r_id;
  logic [7:0]       r_beat_cnt;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_cmd_err;
  logic             r_resp_valid;
  logic [1:0]       r_resp_id;
  logic             r_resp_err;
  logic             r_unexpected_b;

  logic w_illegal;
  logic w_in_data;
  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  axi_burst_check u_burst_check (
    .addr    (cmd_addr[11:0]),
    .len     (cmd_len),
    .size    (cmd_size),
    .illegal (w_illegal)
  );

  // Ready-style outputs are gated by rst so every output reads 0 in reset.
  assign cmd_ready = !rst && (r_state == WR_IDLE) &&
                     (r_outstanding < CNT_W'(MAX_OUTSTANDING));
  assign w_cmd_hs  = cmd_valid && cmd_ready;

  assign AWVALID = (r_state == WR_ADDR);
  assign AWID    = r_id;
  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWSIZE  = r_size;
  assign AWBURST = AWVALID ? BURST_INCR : BURST_FIXED;
  assign w_aw_hs = AWVALID && AWREADY;

  assign w_in_data = (r_state == WR_DATA);
  assign WVALID    = w_in_data && din_valid;
  assign din_ready = w_in_data && WREADY;
  assign WDATA     = w_in_data ? din_data : '0;
  assign WSTRB     = w_in_data ? din_strb : '0;
  assign WLAST     = w_in_data && (r_beat_cnt == r_len);
  assign w_w_hs    = WVALID && WREADY;

  assign BREADY = !rst;
  assign w_b_hs = BVALID && BREADY;

  assign cmd_err      = r_cmd_err;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_err     = r_resp_err;
  assign unexpected_b = r_unexpected_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WR_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_id       <= '0;
      r_beat_cnt <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_hs && w_illegal;
      case (r_state)
        WR_IDLE: begin
          if (w_cmd_hs && !w_illegal) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_size  <= cmd_size;
            r_id    <= cmd_id;
            r_state <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (AWREADY) begin
            r_beat_cnt <= '0;
            r_state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (WLAST) begin
              r_state <= WR_IDLE;
            end
          end
        end
        default: r_state <= WR_IDLE;
      endcase
    end
  end

  // A coincident AW and B handshake leaves the outstanding count untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding  <= '0;
      r_unexpected_b <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_err     <= 1'b0;
    end else begin
      r_resp_valid <= w_b_hs;
      if (w_b_hs) begin
        r_resp_id  <= BID;
        r_resp_err <= (BRESP != RESP_OKAY);
      end
      if (w_aw_hs && !w_b_hs) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_aw_hs && w_b_hs) begin
        if (r_outstanding == '0) begin
          r_unexpected_b <= 1'b1;
        end else begin
          r_outstanding <= r_outstanding - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_axi_write_initiator                                   |
// | Brief    : Directed scoreboard bench for axi_write_initiator        |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_axi_write_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_id = '0;
  logic        cmd_err;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] din_data = '0;
  logic [7:0]  din_strb = '0;
  logic [1:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY = 1'b1;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b1;
  logic [1:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_err;
  logic        unexpected_b;

  always #5 clk = ~clk;

  axi_write_initiator #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_id(cmd_id), .cmd_err(cmd_err),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_strb(din_strb),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .unexpected_b(unexpected_b)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] id; } aw_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
  typedef struct { logic [1:0] id; logic err; } b_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  b_t  exp_b[$];
  bit  exp_err[$];
  aw_t m_aw;
  w_t  m_w;
  b_t  m_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_total++;
    n_fail++;
    $error("FAIL %s: observed=event expected=none", tag);
  endtask

  function automatic bit legal(input logic [31:0] a, input int len, input int size);
    int off;
    off = int'(a % 32'd4096);
    return (size <= 3) && (off + (len + 1) * (1 << size) <= 4096);
  endfunction

  function automatic logic [63:0] pat(input int tag, input int i);
    return {32'(tag) ^ 32'hDEAD_0000, 32'(i) * 32'h0101_0101 + 32'h1357};
  endfunction

  function automatic logic [7:0] stb(input int i);
    return 8'hFF ^ 8'(i * 3);
  endfunction

  // Monitor: pops scoreboard entries as the DUT produces each event.
  always @(negedge clk) begin
    if (!rst) begin
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          m_aw = exp_aw.pop_front();
          chk("aw_addr", AWADDR, m_aw.addr);
          chk("aw_len", AWLEN, m_aw.len);
          chk("aw_size", AWSIZE, m_aw.size);
          chk("aw_id", AWID, m_aw.id);
          chk("aw_burst", AWBURST, 2'b01);
        end
      end
      if (WVALID) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else if (WREADY) begin
          m_w = exp_w.pop_front();
          chk("w_data", WDATA, m_w.data);
          chk("w_strb", WSTRB, m_w.strb);
          chk("w_last", WLAST, m_w.last);
        end else begin
          chk("w_last_stall", WLAST, exp_w[0].last);
        end
      end
      if (resp_valid) begin
        if (exp_b.size() == 0) fail_now("resp_unexpected");
        else begin
          m_b = exp_b.pop_front();
          chk("resp_id", resp_id, m_b.id);
          chk("resp_err", resp_err, m_b.err);
        end
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) fail_now("cmd_err_unexpected");
        else void'(exp_err.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int len, input int size, input int id);
    int guard;
    bit ok;
    aw_t e;
    if (legal(a, len, size)) begin
      e.addr = a; e.len = 8'(len); e.size = 3'(size); e.id = 2'(id);
      exp_aw.push_back(e);
    end else begin
      exp_err.push_back(1'b1);
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'(size); cmd_id = 2'(id);
    guard = 0; ok = 1'b0;
    while (!ok && guard < 100) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; guard++;
    end
    cmd_valid = 1'b0;
    if (!ok) fail_now("cmd_timeout");
  endtask

  task automatic send_beats(input int n, input int total, input int tag, input bit toggle);
    int sent;
    int guard;
    bit hs;
    w_t e;
    for (int i = 0; i < n; i++) begin
      e.data = pat(tag, i); e.strb = stb(i); e.last = (i == total - 1);
      exp_w.push_back(e);
    end
    sent = 0; guard = 0;
    din_valid = 1'b1; din_data = pat(tag, 0); din_strb = stb(0);
    while (sent < n && guard < 100) begin
      @(negedge clk); hs = din_valid && din_ready;
      @(posedge clk); #1; guard++;
      if (hs) sent++;
      if (toggle) WREADY = ~WREADY;
      if (sent < n) begin
        din_data = pat(tag, sent); din_strb = stb(sent);
      end else begin
        din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
    if (sent < n) fail_now("w_timeout");
  endtask

  task automatic send_b(input int id, input logic [1:0] resp);
    b_t e;
    e.id = 2'(id); e.err = (resp != 2'b00);
    exp_b.push_back(e);
    BVALID = 1'b1; BID = 2'(id); BRESP = resp;
    @(posedge clk); #1;
    BVALID = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_aw"}, {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID}, '0);
    chk({tag, "_wdata"}, WDATA, '0);
    chk({tag, "_misc"}, {cmd_ready, cmd_err, din_ready, WSTRB, WLAST, WVALID, BREADY,
                         resp_valid, resp_id, resp_err, unexpected_b}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);
    chk("bready_after_reset", BREADY, 1'b1);
    @(posedge clk); #1;

    // Single-beat burst
    send_cmd(32'h100, 0, 3, 1);
    @(negedge clk);
    chk("awvalid_one_after_accept", AWVALID, 1'b1);
    send_beats(1, 1, 1, 1'b0);
    @(negedge clk);
    chk("cmd_ready_after_wlast", cmd_ready, 1'b1);
    @(posedge clk); #1;
    send_b(1, 2'b00);
    repeat (2) @(posedge clk); #1;

    // 4-beat burst with AWREADY stall and WREADY toggling
    AWREADY = 1'b0;
    send_cmd(32'h200, 3, 3, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("aw_stall_valid", AWVALID, 1'b1);
      chk("aw_stall_addr", AWADDR, 32'h200);
      chk("aw_stall_len", AWLEN, 8'd3);
      @(posedge clk); #1;
    end
    AWREADY = 1'b1;
    send_beats(4, 4, 2, 1'b1);
    WREADY = 1'b1;
    chk("four_beats_consumed", 64'(exp_w.size()), 64'd0);
    send_b(2, 2'b00);
    repeat (2) @(posedge clk); #1;

    // Illegal and boundary bursts
    send_cmd(32'hFF8, 1, 3, 0);
    send_cmd(32'h0, 0, 4, 0);
    repeat (2) @(negedge clk);
    chk("no_aw_after_reject", AWVALID, 1'b0);
    chk("cmd_err_seen", 64'(exp_err.size()), 64'd0);
    @(posedge clk); #1;
    send_cmd(32'hF00, 31, 3, 1);
    send_beats(32, 32, 3, 1'b0);
    send_b(1, 2'b00);
    send_cmd(32'hFF8, 0, 3, 3);
    send_beats(1, 1, 4, 1'b0);
    send_b(3, 2'b00);
    repeat (2) @(posedge clk); #1;

    // Outstanding limit
    for (int k = 0; k < 4; k++) begin
      send_cmd(32'h1000 * k + 32'h40, 0, 3, k);
      send_beats(1, 1, 10 + k, 1'b0);
    end
    @(negedge clk);
    chk("cmd_ready_at_limit", cmd_ready, 1'b0);
    @(posedge clk); #1;
    send_b(0, 2'b00);
    @(negedge clk);
    chk("cmd_ready_after_one_b", cmd_ready, 1'b1);
    @(posedge clk); #1;
    AWREADY = 1'b0;
    send_cmd(32'h5000, 0, 3, 2);
    AWREADY = 1'b1;
    send_b(1, 2'b00);
    send_beats(1, 1, 20, 1'b0);
    @(negedge clk);
    chk("cmd_ready_after_coincident", cmd_ready, 1'b1);
    @(posedge clk); #1;
    send_cmd(32'h6000, 0, 3, 3);
    send_beats(1, 1, 21, 1'b0);
    @(negedge clk);
    chk("cmd_ready_limit_again", cmd_ready, 1'b0);
    @(posedge clk); #1;
    send_b(0, 2'b00);
    send_b(1, 2'b10);
    send_b(2, 2'b00);
    send_b(3, 2'b00);
    @(negedge clk);
    chk("no_unexpected_b_after_drain", unexpected_b, 1'b0);
    chk("cmd_ready_after_drain", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // B with nothing outstanding
    send_b(2, 2'b10);
    repeat (3) @(negedge clk);
    chk("unexpected_b_sticky", unexpected_b, 1'b1);
    @(posedge clk); #1;

    // Reset during beat 2 of an 8-beat burst
    send_cmd(32'h700, 7, 3, 1);
    send_beats(1, 8, 30, 1'b0);
    din_valid = 1'b1; din_data = pat(30, 1); din_strb = stb(1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_burst_reset");
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    send_cmd(32'h800, 1, 3, 2);
    send_beats(2, 2, 31, 1'b0);
    send_b(2, 2'b00);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("unexpected_b_cleared", unexpected_b, 1'b0);

    chk("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_empty", 64'(exp_w.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    chk("err_queue_empty", 64'(exp_err.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
